// File: rtl/reg_load_pkg.sv
// Shared types and defaults for the round-robin register-load arbiter.
package reg_load_pkg;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/reg_load_arbiter_rr_pick.sv
// Combinational round-robin priority finder: first set request at or after ptr, wrapping.
module rr_pick
  import reg_load_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned PW   = $clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  int unsigned cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!valid && req[cand[PW-1:0]]) begin
        valid                  = 1'b1;
        idx                    = cand[PW-1:0];
        onehot[cand[PW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter driving D/L of a shared load register; one load pulse per grant.
// Optional saturating load counter output LOAD_CNT when REG_LOAD_ARB_COUNT_EN is defined.
module reg_load_arbiter
  import reg_load_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] DIN,
  output logic [NREQ-1:0]       GNT,
  output logic [WIDTH-1:0]      D,
  output logic                  L,
  output logic                  BUSY
`ifdef REG_LOAD_ARB_COUNT_EN
  ,
  output logic [7:0]            LOAD_CNT
`endif
);

  localparam int unsigned PW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_d;
  logic [WIDTH-1:0] d_d;
  logic            l_d;
  logic            busy_d;

  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   win_idx;
  logic            win_valid;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (REQ),
    .ptr    (ptr_q),
    .onehot (win_oh),
    .idx    (win_idx),
    .valid  (win_valid)
  );

  // Every output is computed one cycle ahead and registered, so nothing on
  // REQ/DIN reaches the ports combinationally.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    d_d     = D;
    l_d     = 1'b0;
    case (state_q)
      LOAD: state_d = WAIT;
      IDLE, WAIT: begin
        if (win_valid) begin
          state_d = LOAD;
          gnt_d   = win_oh;
          l_d     = 1'b1;
          d_d     = DIN[win_idx*WIDTH +: WIDTH];
          ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      GNT     <= '0;
      D       <= '0;
      L       <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      GNT     <= gnt_d;
      D       <= d_d;
      L       <= l_d;
      BUSY    <= busy_d;
    end
  end

`ifdef REG_LOAD_ARB_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      LOAD_CNT <= '0;
    end else if (state_q == LOAD && LOAD_CNT != 8'hFF) begin
      LOAD_CNT <= LOAD_CNT + 8'd1;
    end
  end
`else
  // no load counter in this build
`endif

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Randomized + directed bench for reg_load_arbiter against a cycle-level reference model.
module tb_reg_load_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 4;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [NREQ-1:0]       REQ;
  logic [NREQ*WIDTH-1:0] DIN;
  logic [NREQ-1:0]       GNT;
  logic [WIDTH-1:0]      D;
  logic                  L;
  logic                  BUSY;
`ifdef REG_LOAD_ARB_COUNT_EN
  logic [7:0]            LOAD_CNT;
`endif

  logic [WIDTH-1:0] Q = '0;

  always #5 CLK = ~CLK;

  // target register fed by the arbiter
  always @(posedge CLK) if (L) Q <= D;

  reg_load_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .DIN  (DIN),
    .GNT  (GNT),
    .D    (D),
    .L    (L),
    .BUSY (BUSY)
`ifdef REG_LOAD_ARB_COUNT_EN
    ,
    .LOAD_CNT (LOAD_CNT)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: phase 0=idle 1=load 2=wait
  int               m_phase = 0;
  int               m_ptr   = 0;
  logic [NREQ-1:0]  m_gnt   = '0;
  logic             m_l     = 1'b0;
  logic [WIDTH-1:0] m_d     = '0;
  logic [WIDTH-1:0] m_q     = '0;
  int               m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [NREQ-1:0] q,
                            input logic [NREQ*WIDTH-1:0] din);
    int w;
    if (m_l) m_q = m_d;
    if (r) begin
      m_phase = 0; m_ptr = 0; m_gnt = '0; m_l = 1'b0; m_d = '0; m_cnt = 0;
    end else begin
      if (m_phase == 1 && m_cnt < 255) m_cnt++;
      if (m_phase == 1) begin
        m_phase = 2; m_gnt = '0; m_l = 1'b0;
      end else begin
        w = -1;
        for (int k = 0; k < int'(NREQ); k++)
          if (w < 0 && q[(m_ptr + k) % int'(NREQ)]) w = (m_ptr + k) % int'(NREQ);
        if (w >= 0) begin
          m_phase = 1;
          m_gnt   = '0;
          m_gnt[w] = 1'b1;
          m_l     = 1'b1;
          m_d     = din[w*WIDTH +: WIDTH];
          m_ptr   = (w + 1) % int'(NREQ);
        end else begin
          m_phase = 0; m_gnt = '0; m_l = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [NREQ-1:0] q, input logic [NREQ*WIDTH-1:0] din);
    RST = r;
    REQ = q;
    DIN = din;
    @(posedge CLK);
    model_edge(r, q, din);
    #1;
    check("gnt", 32'(GNT), 32'(m_gnt));
    check("l", 32'(L), 32'(m_l));
    check("d", 32'(D), 32'(m_d));
    check("busy", 32'(BUSY), 32'(m_phase != 0));
    check("q", 32'(Q), 32'(m_q));
`ifdef REG_LOAD_ARB_COUNT_EN
    check("load_cnt", 32'(LOAD_CNT), 32'(m_cnt));
`endif
  endtask

  logic [NREQ*WIDTH-1:0] din;

  initial begin
    RST = 1'b1;
    REQ = '0;
    DIN = '0;

    // reset state
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    check("reset_gnt", 32'(GNT), 32'h0);
    check("reset_busy", 32'(BUSY), 32'h0);

    // single requester
    din = '0;
    din[1*WIDTH +: WIDTH] = 4'hF;
    step(1'b0, 4'b0010, din);
    check("single_gnt", 32'(GNT), 32'h2);
    check("single_d", 32'(D), 32'hF);
    check("single_l", 32'(L), 32'h1);
    step(1'b0, 4'b0000, din);
    check("single_q", 32'(Q), 32'hF);
    check("single_wait_busy", 32'(BUSY), 32'h1);
    step(1'b0, 4'b0000, din);
    check("single_idle_busy", 32'(BUSY), 32'h0);

    // all four continuously requesting
    step(1'b1, '0, '0);
    for (int i = 0; i < int'(NREQ); i++) din[i*WIDTH +: WIDTH] = WIDTH'(i + 8);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'b1111, din);
      if (k % 2 == 0) begin
        check("rr_gnt", 32'(GNT), 32'(1) << ((k / 2) % 4));
        check("rr_d", 32'(D), 32'(8 + (k / 2) % 4));
      end else begin
        check("rr_l_low", 32'(L), 32'h0);
      end
    end

    // wrap-around from ptr=3
    step(1'b1, '0, '0);
    din = 16'hA5C3;
    step(1'b0, 4'b0100, din);
    step(1'b0, 4'b0000, din);
    step(1'b0, 4'b0000, din);
    step(1'b0, 4'b1001, din);
    check("wrap_gnt3", 32'(GNT), 32'h8);
    step(1'b0, 4'b1001, din);
    step(1'b0, 4'b1001, din);
    check("wrap_gnt0", 32'(GNT), 32'h1);
    step(1'b0, 4'b0000, din);
    step(1'b0, 4'b0000, din);

    // stale request re-granted straight after WAIT
    step(1'b1, '0, '0);
    step(1'b0, 4'b0100, din);
    check("stale_gnt_a", 32'(GNT), 32'h4);
    step(1'b0, 4'b0100, din);
    step(1'b0, 4'b0100, din);
    check("stale_gnt_b", 32'(GNT), 32'h4);
    step(1'b0, 4'b0000, din);
    step(1'b0, 4'b0000, din);

    // reset at the edge ending a LOAD
    step(1'b1, '0, '0);
    din = '0;
    din[1*WIDTH +: WIDTH] = 4'b0101;
    step(1'b0, 4'b0010, din);
    step(1'b1, 4'b0110, din);
    check("rst_load_q", 32'(Q), 32'h5);
    check("rst_load_l", 32'(L), 32'h0);
    check("rst_load_d", 32'(D), 32'h0);
    step(1'b0, 4'b0110, din);
    check("rst_regrant_ptr0", 32'(GNT), 32'h2);
    step(1'b0, 4'b0000, din);
    step(1'b0, 4'b0000, din);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic r;
      logic [NREQ-1:0] q;
      r = ($urandom_range(0, 63) == 0);
      q = 4'($urandom);
      if ($urandom_range(0, 3) == 0) q = '0;
      step(r, q, 16'($urandom));
    end

`ifdef REG_LOAD_ARB_COUNT_EN
    step(1'b1, '0, '0);
    for (int k = 0; k < 600; k++) step(1'b0, 4'b0001, 16'($urandom));
    check("cnt_saturated", 32'(LOAD_CNT), 32'd255);
    step(1'b1, '0, '0);
    check("cnt_cleared", 32'(LOAD_CNT), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
